// File: rtl/sa_req_responder_if.sv
// sa_req_responder_if: TCA-to-SA request/response channel bundle
interface sa_req_responder_if #(
  parameter int LANES = 4,
  parameter int DW    = 16
);
  logic                sa_req_valid;
  logic                sa_req_load_ifmap;
  logic                sa_req_load_psum;
  logic                sa_req_start;
  logic [LANES*DW-1:0] sa_req_din;
  logic                sa_res_valid;
  logic                sa_res_done;
  logic [LANES*DW-1:0] sa_res_dout;
  logic                sa_err;
  modport master (
    output sa_req_valid, sa_req_load_ifmap, sa_req_load_psum, sa_req_start, sa_req_din,
    input  sa_res_valid, sa_res_done, sa_res_dout, sa_err
  );
  modport slave (
    input  sa_req_valid, sa_req_load_ifmap, sa_req_load_psum, sa_req_start, sa_req_din,
    output sa_res_valid, sa_res_done, sa_res_dout, sa_err
  );
endinterface

// File: rtl/sa_req_responder.sv
// sa_req_responder: SA-side endpoint buffering ifmap/psum rows and returning summed rows after a fill latency
module sa_req_responder #(
  parameter int LANES   = 4,
  parameter int DW      = 16,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 3
) (
  input logic            CLK,
  input logic            RST,
  sa_req_responder_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;
  state_t state, state_nxt;
  logic [LANES*DW-1:0] ifm [DEPTH];
  logic [LANES*DW-1:0] psm [DEPTH];
  logic [CW-1:0] if_cnt, ps_cnt, n, n_new, idx;
  logic [7:0] lat;
  logic [LANES*DW-1:0] sum, dout_q;
  logic empty_done, err;
  logic req, if_full, ps_full, wr_if, wr_ps, go, last;
  assign req     = state == IDLE && bus.sa_req_valid;
  assign if_full = if_cnt == CW'(DEPTH);
  assign ps_full = ps_cnt == CW'(DEPTH);
  assign wr_if   = req && bus.sa_req_load_ifmap && !if_full;
  assign wr_ps   = req && bus.sa_req_load_psum && !ps_full;
  assign n_new   = if_cnt + CW'(wr_if);
  assign go      = req && bus.sa_req_start;
  assign last    = state == OUT && idx == n - CW'(1);
  assign bus.sa_res_valid = state == OUT;
  assign bus.sa_res_done  = last || empty_done;
  assign bus.sa_res_dout  = state == OUT ? sum : dout_q;
  assign bus.sa_err       = err;
  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end
  // next state: zero fill latency skips COMPUTE so the first row appears the cycle after start
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = go && n_new != '0 ? (LATENCY == 0 ? OUT : COMPUTE) : IDLE;
      COMPUTE: state_nxt = lat == 8'd1 ? OUT : COMPUTE;
      OUT:     state_nxt = last ? IDLE : OUT;
      default: state_nxt = IDLE;
    endcase
  end
  // lane-wise wrapping sum of the current row; rows beyond the psum count add zero
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++)
      sum[k*DW +: DW] = ifm[idx[AW-1:0]][k*DW +: DW] + (idx < ps_cnt ? psm[idx[AW-1:0]][k*DW +: DW] : DW'(0));
  end
  // row buffers, written only while idle
  always_ff @(posedge CLK) begin
    if (wr_if) ifm[if_cnt[AW-1:0]] <= bus.sa_req_din;
    if (wr_ps) psm[ps_cnt[AW-1:0]] <= bus.sa_req_din;
  end
  // counters, latency timer, output hold and sticky error
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_cnt     <= '0;
      ps_cnt     <= '0;
      n          <= '0;
      idx        <= '0;
      lat        <= '0;
      dout_q     <= '0;
      empty_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_cnt     <= last || (go && n_new == '0) ? '0 : if_cnt + CW'(wr_if);
      ps_cnt     <= last || (go && n_new == '0) ? '0 : ps_cnt + CW'(wr_ps);
      n          <= go ? n_new : n;
      idx        <= state == OUT && !last ? idx + CW'(1) : '0;
      lat        <= go ? 8'(LATENCY) : state == COMPUTE ? lat - 8'd1 : lat;
      dout_q     <= state == OUT ? sum : dout_q;
      empty_done <= go && n_new == '0;
      err        <= err || (bus.sa_req_valid && state != IDLE)
                        || (req && bus.sa_req_load_ifmap && if_full)
                        || (req && bus.sa_req_load_psum && ps_full);
    end
  end
endmodule

// File: tb/tb_sa_req_responder.sv
// tb_sa_req_responder: directed self-checking bench for sa_req_responder
module tb_sa_req_responder;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int tests = 0;
  int fails = 0;
  sa_req_responder_if #(.LANES(4), .DW(16)) bus ();
  sa_req_responder #(.LANES(4), .DW(16), .DEPTH(8), .LATENCY(3)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  function automatic logic [63:0] row(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic drv(input logic v, li, lp, st, input logic [63:0] d);
    bus.sa_req_valid = v;
    bus.sa_req_load_ifmap = li;
    bus.sa_req_load_psum = lp;
    bus.sa_req_start = st;
    bus.sa_req_din = d;
    step();
    bus.sa_req_valid = 1'b0;
    bus.sa_req_load_ifmap = 1'b0;
    bus.sa_req_load_psum = 1'b0;
    bus.sa_req_start = 1'b0;
    bus.sa_req_din = '0;
  endtask
  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++; if (bus.sa_res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.sa_res_valid); end
    tests++; if (bus.sa_res_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.sa_res_done); end
    tests++; if (bus.sa_res_dout !== 64'h0) begin fails++; $display("FAIL reset_dout: got %h want 0", bus.sa_res_dout); end
    tests++; if (bus.sa_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.sa_err); end
  endtask
  task automatic test_basic();
    drv(1, 1, 0, 0, row(1, 2, 3, 4));
    drv(1, 1, 0, 0, row(5, 6, 7, 8));
    drv(1, 0, 1, 0, row(10, 10, 10, 10));
    drv(1, 0, 1, 0, row(0, 0, 0, 1));
    drv(1, 0, 0, 1, '0);
    for (int c = 1; c <= 3; c++) begin
      tests++; if (bus.sa_res_valid !== 1'b0) begin fails++; $display("FAIL basic_latency T+%0d: valid got %b want 0", c, bus.sa_res_valid); end
      step();
    end
    tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_done !== 1'b0) begin fails++; $display("FAIL basic_row0_flags: valid/done got %b%b want 10", bus.sa_res_valid, bus.sa_res_done); end
    tests++; if (bus.sa_res_dout !== row(11, 12, 13, 14)) begin fails++; $display("FAIL basic_row0: got %h want %h", bus.sa_res_dout, row(11, 12, 13, 14)); end
    step();
    tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_done !== 1'b1) begin fails++; $display("FAIL basic_row1_flags: valid/done got %b%b want 11", bus.sa_res_valid, bus.sa_res_done); end
    tests++; if (bus.sa_res_dout !== row(5, 6, 7, 9)) begin fails++; $display("FAIL basic_row1: got %h want %h", bus.sa_res_dout, row(5, 6, 7, 9)); end
    step();
    tests++; if (bus.sa_res_valid !== 1'b0 || bus.sa_res_done !== 1'b0) begin fails++; $display("FAIL basic_after: valid/done got %b%b want 00", bus.sa_res_valid, bus.sa_res_done); end
    tests++; if (bus.sa_res_dout !== row(5, 6, 7, 9)) begin fails++; $display("FAIL basic_hold: got %h want %h", bus.sa_res_dout, row(5, 6, 7, 9)); end
    tests++; if (bus.sa_err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", bus.sa_err); end
  endtask
  task automatic test_wrap();
    drv(1, 1, 0, 0, row(16'hFFFF, 1, 0, 0));
    drv(1, 1, 0, 0, row(7, 7, 7, 7));
    drv(1, 0, 1, 0, row(2, 0, 0, 0));
    drv(1, 0, 0, 1, '0);
    step(); step(); step();
    tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_dout !== row(1, 1, 0, 0) || bus.sa_res_done !== 1'b0) begin fails++; $display("FAIL wrap_row0: v%b d%b got %h want %h", bus.sa_res_valid, bus.sa_res_done, bus.sa_res_dout, row(1, 1, 0, 0)); end
    step();
    tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_dout !== row(7, 7, 7, 7) || bus.sa_res_done !== 1'b1) begin fails++; $display("FAIL wrap_row1: v%b d%b got %h want %h", bus.sa_res_valid, bus.sa_res_done, bus.sa_res_dout, row(7, 7, 7, 7)); end
    step();
    tests++; if (bus.sa_res_valid !== 1'b0) begin fails++; $display("FAIL wrap_end: valid got %b want 0", bus.sa_res_valid); end
  endtask
  task automatic test_empty();
    drv(1, 0, 0, 1, '0);
    tests++; if (bus.sa_res_done !== 1'b1 || bus.sa_res_valid !== 1'b0) begin fails++; $display("FAIL empty_done: done/valid got %b%b want 10", bus.sa_res_done, bus.sa_res_valid); end
    step();
    tests++; if (bus.sa_res_done !== 1'b0 || bus.sa_res_valid !== 1'b0) begin fails++; $display("FAIL empty_after: done/valid got %b%b want 00", bus.sa_res_done, bus.sa_res_valid); end
    for (int c = 0; c < 4; c++) begin
      step();
      tests++; if (bus.sa_res_valid !== 1'b0) begin fails++; $display("FAIL empty_novalid %0d: got %b want 0", c, bus.sa_res_valid); end
    end
    tests++; if (bus.sa_err !== 1'b0) begin fails++; $display("FAIL empty_err: got %b want 0", bus.sa_err); end
  endtask
  task automatic test_overflow();
    for (int r = 0; r < 9; r++) drv(1, 1, 0, 0, row(16'(r), 16'(r + 100), 16'(r * 3), 16'hA000));
    tests++; if (bus.sa_err !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b want 1", bus.sa_err); end
    drv(1, 0, 0, 1, '0);
    step(); step(); step();
    for (int r = 0; r < 8; r++) begin
      tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_dout !== row(16'(r), 16'(r + 100), 16'(r * 3), 16'hA000) || bus.sa_res_done !== (r == 7)) begin fails++; $display("FAIL ovf_row%0d: v%b d%b got %h want %h", r, bus.sa_res_valid, bus.sa_res_done, bus.sa_res_dout, row(16'(r), 16'(r + 100), 16'(r * 3), 16'hA000)); end
      step();
    end
    tests++; if (bus.sa_res_valid !== 1'b0) begin fails++; $display("FAIL ovf_count: valid after 8 rows got %b want 0", bus.sa_res_valid); end
    do_reset();
  endtask
  task automatic test_load_start();
    drv(1, 1, 0, 1, row(3, 3, 3, 3));
    drv(1, 1, 0, 0, row(9, 9, 9, 9));
    tests++; if (bus.sa_err !== 1'b1) begin fails++; $display("FAIL ls_violation_err: got %b want 1", bus.sa_err); end
    step(); step();
    tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_done !== 1'b1 || bus.sa_res_dout !== row(3, 3, 3, 3)) begin fails++; $display("FAIL ls_row: v%b d%b got %h want %h", bus.sa_res_valid, bus.sa_res_done, bus.sa_res_dout, row(3, 3, 3, 3)); end
    step();
    tests++; if (bus.sa_res_valid !== 1'b0 || bus.sa_err !== 1'b1) begin fails++; $display("FAIL ls_after: valid/err got %b%b want 01", bus.sa_res_valid, bus.sa_err); end
    do_reset();
  endtask
  task automatic test_reset_mid();
    for (int r = 0; r < 4; r++) drv(1, 1, 0, 0, row(16'(r + 20), 0, 0, 0));
    drv(1, 0, 0, 1, '0);
    step(); step(); step();
    step();
    tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_dout !== row(21, 0, 0, 0)) begin fails++; $display("FAIL rm_row1: v%b got %h want %h", bus.sa_res_valid, bus.sa_res_dout, row(21, 0, 0, 0)); end
    RST = 1'b1;
    step();
    tests++; if (bus.sa_res_valid !== 1'b0 || bus.sa_res_done !== 1'b0 || bus.sa_res_dout !== 64'h0) begin fails++; $display("FAIL rm_abort: v%b d%b got %h want 0", bus.sa_res_valid, bus.sa_res_done, bus.sa_res_dout); end
    RST = 1'b0;
    step();
    tests++; if (bus.sa_res_valid !== 1'b0 || bus.sa_res_done !== 1'b0) begin fails++; $display("FAIL rm_quiet: valid/done got %b%b want 00", bus.sa_res_valid, bus.sa_res_done); end
    drv(1, 1, 0, 0, row(4, 5, 6, 7));
    drv(1, 0, 0, 1, '0);
    step(); step(); step();
    tests++; if (bus.sa_res_valid !== 1'b1 || bus.sa_res_done !== 1'b1 || bus.sa_res_dout !== row(4, 5, 6, 7)) begin fails++; $display("FAIL rm_fresh: v%b d%b got %h want %h", bus.sa_res_valid, bus.sa_res_done, bus.sa_res_dout, row(4, 5, 6, 7)); end
    step();
    tests++; if (bus.sa_res_valid !== 1'b0 || bus.sa_err !== 1'b0) begin fails++; $display("FAIL rm_end: valid/err got %b%b want 00", bus.sa_res_valid, bus.sa_err); end
  endtask
  initial begin
    bus.sa_req_valid = 1'b0;
    bus.sa_req_load_ifmap = 1'b0;
    bus.sa_req_load_psum = 1'b0;
    bus.sa_req_start = 1'b0;
    bus.sa_req_din = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_empty();
    test_overflow();
    test_load_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sa_req_responder.md
Name: sa_req_responder

Overview:
- Systolic-array-side endpoint of the TCA-to-SA request/response channel.
- Consumes the stream the TCA drives on sa_req: ifmap rows, psum rows and a start strobe. Buffers the rows locally, models the array fill latency, then returns one result row per cycle on sa_res, with done on the last row.
- Serves as the synthesizable SA stand-in for TCA integration and as the input/output sequencer wrapped around the real array later.

Parameters:
- LANES, 4, data lanes per row (elements in one din/dout word).
- DW, 16, bits per lane.
- DEPTH, 8, max rows held per buffer (ifmap and psum each); power of two.
- LATENCY, 3, idle cycles between start acceptance and first result (array fill); 0..255.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- sa_req_valid  in  1  request valid this cycle.
- sa_req_load_ifmap  in  1  din is an ifmap row.
- sa_req_load_psum  in  1  din is a psum row.
- sa_req_start  in  1  begin compute on buffered rows.
- sa_req_din  in  LANES*DW  row data; lane k = bits [k*DW +: DW].
- sa_res_valid  out  1  result row valid.
- sa_res_done  out  1  operation finished.
- sa_res_dout  out  LANES*DW  result row.
- sa_err  out  1  sticky protocol error.

Behaviour:
- Interface (already decided): one clock CLK; RST is synchronous and active-high.
- Reset:
  - All outputs reset to 0; state returns to IDLE.
  - if_cnt and ps_cnt reset to 0; buffer contents need not be reset.
  - Reset mid-operation aborts immediately; no done is issued.
- No backpressure: the responder samples sa_req every cycle it is in IDLE. The TCA must not send rows during compute.
- States: IDLE, COMPUTE, OUT.
- IDLE, per cycle with sa_req_valid=1:
  - load_ifmap=1: write din to ifm[if_cnt] and increment if_cnt.
  - load_psum=1: write din to psm[ps_cnt] and increment ps_cnt.
  - Both flags set: the same din is written to both buffers.
  - Buffer already holding DEPTH rows: that write is dropped, the count holds and sa_err is set.
- start=1 with valid=1 in IDLE:
  - Any load in the same cycle is applied first, so that row is included.
  - N is latched as the post-load if_cnt.
  - N>0: go to COMPUTE with the latency counter set to LATENCY.
  - N==0: the next cycle pulses sa_res_done=1 with sa_res_valid=0; stay IDLE.
- COMPUTE: the latency counter decrements each cycle. Transition to OUT so that the first sa_res_valid is asserted exactly LATENCY+1 cycles after the start cycle.
- OUT:
  - Row i (i=0..N-1) is emitted on consecutive cycles with sa_res_valid=1.
  - dout lane k = (ifm[i].k + psm[i].k) mod 2^DW (wrapping, unsigned).
  - If i >= ps_cnt, the psum is taken as 0 and dout = ifm[i].
  - sa_res_done=1 in the same cycle as row N-1.
  - Next cycle: IDLE, with if_cnt=ps_cnt=0.
- sa_res_dout holds its last value when valid=0. Only the valid-qualified value is meaningful.
- Any sa_req_valid=1 in COMPUTE or OUT is ignored and sets sa_err.
- sa_err stays set until RST.
- Extra psum rows (ps_cnt > N) are discarded when the operation completes.

Test Plan:
- Basic (LANES=4, DW=16, LATENCY=3):
  - Stimulus: load ifmap rows {1,2,3,4} and {5,6,7,8}, load psum rows {10,10,10,10} and {0,0,0,1}, start at cycle T.
  - Required: valid at T+4 with dout {11,12,13,14}; at T+5 with {5,6,7,9} and done=1; sa_err=0.
- Wrap and missing psum:
  - Stimulus: ifmap {0xFFFF,1,0,0} and {7,7,7,7}, one psum row {2,0,0,0}, start.
  - Required: rows {0x0001,1,0,0} then {7,7,7,7}; done on the second row.
- Empty start: start with no loads -> done=1 one cycle later, valid never asserted.
- Overflow:
  - Stimulus: load 9 ifmap rows (DEPTH=8), then start.
  - Required: sa_err=1; exactly 8 rows returned, matching rows 0..7.
- Load+start same cycle and protocol violation:
  - Stimulus: single cycle with valid, load_ifmap, start and din={3,3,3,3}.
  - Required: one row {3,3,3,3}. A load issued during COMPUTE sets sa_err and does not alter the output.
- Reset mid-OUT: RST asserted during the second of 4 output rows -> outputs 0 the next cycle, no done; a fresh 1-row op afterwards completes normally.
